// File: rtl/hazard_ctrl_if.sv
// Hazard-controller handshake bundle: decode/execute observations in, pipeline
// stall/flush enables out.
interface hazard_ctrl_if #(
    parameter int OPTYPE_W = 6,
    parameter int REG_W    = 5
);
    logic [OPTYPE_W-1:0] dOptype;
    logic [REG_W-1:0]    dRd;
    logic [REG_W-1:0]    fRs1;
    logic [REG_W-1:0]    fRs2;
    logic                fUse1;
    logic                fUse2;
    logic                eRedirect;
    logic                pcStall;
    logic                fStall;
    logic                dStall;
    logic                fFlush;
    logic                dFlush;
    logic                eFlush;
    logic                busy;

    modport master (
        output dOptype, dRd, fRs1, fRs2, fUse1, fUse2, eRedirect,
        input  pcStall, fStall, dStall, fFlush, dFlush, eFlush, busy
    );

    modport slave (
        input  dOptype, dRd, fRs1, fRs2, fUse1, fUse2, eRedirect,
        output pcStall, fStall, dStall, fFlush, dFlush, eFlush, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-bubble load-use, multi-cycle MDU occupancy
// of E, and branch/jump redirect flushes, with a small counter FSM.
module hazard_ctrl #(
    parameter int OPTYPE_W     = 6,
    parameter int REG_W        = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MDU_LAT      = 4,
    parameter int MDU_OP_LO    = 36,
    parameter int MDU_OP_HI    = 43
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int MAX_CNT = (LOAD_BUBBLES > MDU_LAT) ? LOAD_BUBBLES : MDU_LAT;
    localparam int CNT_W   = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LU_WAIT = 2'd1,
        MDU_RUN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_load_s, is_mdu_s, lu_hit_s;
    logic pc_stall_s, f_stall_s, d_stall_s, f_flush_s, d_flush_s, e_flush_s, busy_s;

    function automatic logic is_load_op(input logic [OPTYPE_W-1:0] op);
        return (op >= OPTYPE_W'(21)) && (op <= OPTYPE_W'(25));
    endfunction

    // Classify the ID/EX instruction and detect a dependent consumer in IF/ID.
    always_comb begin
        is_load_s = is_load_op(hz.dOptype);
        is_mdu_s  = (hz.dOptype >= OPTYPE_W'(MDU_OP_LO)) && (hz.dOptype <= OPTYPE_W'(MDU_OP_HI));
        lu_hit_s  = is_load_s && (hz.dRd != {REG_W{1'b0}}) &&
                    ((hz.fUse1 && (hz.fRs1 == hz.dRd)) || (hz.fUse2 && (hz.fRs2 == hz.dRd)));
    end

    // Next-state, counter and stall/flush enables.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_stall_s = 1'b0;
        f_stall_s  = 1'b0;
        d_stall_s  = 1'b0;
        f_flush_s  = 1'b0;
        d_flush_s  = 1'b0;
        e_flush_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.eRedirect) begin
                    f_flush_s = 1'b1;
                    d_flush_s = 1'b1;
                end else if (lu_hit_s) begin
                    pc_stall_s = 1'b1;
                    f_stall_s  = 1'b1;
                    d_flush_s  = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        cnt_d   = CNT_W'(LOAD_BUBBLES - 2);
                        state_d = LU_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (is_mdu_s) begin
                    pc_stall_s = 1'b1;
                    f_stall_s  = 1'b1;
                    d_stall_s  = 1'b1;
                    e_flush_s  = 1'b1;
                    cnt_d      = CNT_W'(MDU_LAT - 2);
                    state_d    = MDU_RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            LU_WAIT: begin
                // E holds a bubble here, so a redirect is not expected, but it still wins.
                if (hz.eRedirect) begin
                    f_flush_s = 1'b1;
                    d_flush_s = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = IDLE;
                end else begin
                    pc_stall_s = 1'b1;
                    f_stall_s  = 1'b1;
                    d_flush_s  = 1'b1;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            MDU_RUN: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    pc_stall_s = 1'b1;
                    f_stall_s  = 1'b1;
                    d_stall_s  = 1'b1;
                    e_flush_s  = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        busy_s = (state_q != IDLE);
        if (rst) begin
            pc_stall_s = 1'b0;
            f_stall_s  = 1'b0;
            d_stall_s  = 1'b0;
            f_flush_s  = 1'b0;
            d_flush_s  = 1'b0;
            e_flush_s  = 1'b0;
            busy_s     = 1'b0;
        end else begin
            busy_s = busy_s;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pcStall = pc_stall_s;
    assign hz.fStall  = f_stall_s;
    assign hz.dStall  = d_stall_s;
    assign hz.fFlush  = f_flush_s;
    assign hz.dFlush  = d_flush_s;
    assign hz.eFlush  = e_flush_s;
    assign hz.busy    = busy_s;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two instances (LOAD_BUBBLES=1 and 3, MDU_LAT=4) share stimulus;
// outputs packed as {pcStall,fStall,dStall,fFlush,dFlush,eFlush,busy}.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    logic [5:0] d_optype;
    logic [4:0] d_rd, f_rs1, f_rs2;
    logic f_use1, f_use2, e_redirect;
    logic [6:0] obs_a, obs_b;
    int n_vec;
    int n_err;

    localparam logic [6:0] Z     = 7'b0000000;
    localparam logic [6:0] LU    = 7'b1100100;
    localparam logic [6:0] LU_B  = 7'b1100101;
    localparam logic [6:0] MDU   = 7'b1110010;
    localparam logic [6:0] MDU_B = 7'b1110011;
    localparam logic [6:0] RD    = 7'b0001100;
    localparam logic [6:0] RD_B  = 7'b0001101;
    localparam logic [6:0] BSY   = 7'b0000001;

    hazard_ctrl_if #(.OPTYPE_W(6), .REG_W(5)) if_a ();
    hazard_ctrl_if #(.OPTYPE_W(6), .REG_W(5)) if_b ();

    hazard_ctrl #(.LOAD_BUBBLES(1), .MDU_LAT(4)) u_a (.clk(clk), .rst(rst), .hz(if_a.slave));
    hazard_ctrl #(.LOAD_BUBBLES(3), .MDU_LAT(4)) u_b (.clk(clk), .rst(rst), .hz(if_b.slave));

    assign if_a.dOptype = d_optype;   assign if_b.dOptype = d_optype;
    assign if_a.dRd = d_rd;           assign if_b.dRd = d_rd;
    assign if_a.fRs1 = f_rs1;         assign if_b.fRs1 = f_rs1;
    assign if_a.fRs2 = f_rs2;         assign if_b.fRs2 = f_rs2;
    assign if_a.fUse1 = f_use1;       assign if_b.fUse1 = f_use1;
    assign if_a.fUse2 = f_use2;       assign if_b.fUse2 = f_use2;
    assign if_a.eRedirect = e_redirect;
    assign if_b.eRedirect = e_redirect;

    assign obs_a = {if_a.pcStall, if_a.fStall, if_a.dStall, if_a.fFlush, if_a.dFlush, if_a.eFlush, if_a.busy};
    assign obs_b = {if_b.pcStall, if_b.fStall, if_b.dStall, if_b.fFlush, if_b.dFlush, if_b.eFlush, if_b.busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2, input logic redir);
        d_optype = op; d_rd = rd; f_rs1 = rs1; f_rs2 = rs2;
        f_use1 = u1; f_use2 = u2; e_redirect = redir;
    endtask

    // Sample both instances mid-cycle, then advance past the next rising edge.
    task automatic chk(input string tag, input logic [6:0] ea, input logic [6:0] eb);
        @(negedge clk);
        n_vec = n_vec + 2;
        assert (obs_a === ea) else begin
            n_err = n_err + 1;
            $error("FAIL %s lb1 observed=%b expected=%b", tag, obs_a, ea);
        end
        assert (obs_b === eb) else begin
            n_err = n_err + 1;
            $error("FAIL %s lb3 observed=%b expected=%b", tag, obs_b, eb);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        // Reset overrides a live load-use hit.
        set_in(6'd23, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        chk("reset_forces_zero", Z, Z);
        rst = 1'b0;
        set_in(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_after_reset", Z, Z);

        // LH x7 consumed via rs1.
        set_in(6'd22, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0);
        chk("lu_rs1_c1", LU, LU);
        set_in(6'd0, 5'd0, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0);
        chk("lu_rs1_c2", Z, LU_B);
        chk("lu_rs1_c3", Z, LU_B);
        chk("lu_rs1_done", Z, Z);

        // LW x5 via rs2; redirect then arrives while lb3 is in LU_WAIT.
        set_in(6'd23, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        chk("lu_rs2_c1", LU, LU);
        set_in(6'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
        chk("redirect_in_luwait", RD, RD_B);
        set_in(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("after_luwait_redirect", Z, Z);

        // Loads that must not stall, and optype range edges.
        set_in(6'd23, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("load_rd0", Z, Z);
        set_in(6'd24, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0);
        chk("load_nouse", Z, Z);
        set_in(6'd20, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("optype20_not_load", Z, Z);
        set_in(6'd26, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("optype26_not_load", Z, Z);
        set_in(6'd35, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("optype35_not_mdu", Z, Z);
        set_in(6'd44, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("optype44_not_mdu", Z, Z);

        // MDU op 40 held in E, then a back-to-back op 43 with an ignored redirect.
        set_in(6'd40, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("mdu1_c1", MDU, MDU);
        chk("mdu1_c2", MDU_B, MDU_B);
        chk("mdu1_c3", MDU_B, MDU_B);
        chk("mdu1_c4", BSY, BSY);
        set_in(6'd43, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("mdu2_c1", MDU, MDU);
        e_redirect = 1'b1;
        chk("mdu2_c2_redirect_ignored", MDU_B, MDU_B);
        e_redirect = 1'b0;
        chk("mdu2_c3", MDU_B, MDU_B);
        chk("mdu2_c4", BSY, BSY);

        // MDU to load-use chain with no gap (LHU x9 via rs1).
        set_in(6'd36, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("mdu3_c1", MDU, MDU);
        chk("mdu3_c2", MDU_B, MDU_B);
        chk("mdu3_c3", MDU_B, MDU_B);
        chk("mdu3_c4", BSY, BSY);
        set_in(6'd25, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("chain_lu_c1", LU, LU);
        set_in(6'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("chain_lu_c2", Z, LU_B);
        chk("chain_lu_c3", Z, LU_B);
        chk("chain_lu_done", Z, Z);

        // Redirect together with a load-use hit in IDLE.
        set_in(6'd21, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("redirect_beats_lu", RD, RD);
        set_in(6'd0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("after_redirect_idle", Z, Z);

        // Reset during cycle 2 of an MDU stall.
        set_in(6'd40, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("mdu_rst_c1", MDU, MDU);
        rst = 1'b1;
        chk("mdu_rst_held", Z, Z);
        rst = 1'b0;
        set_in(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_idle", Z, Z);
        chk("post_rst_quiet", Z, Z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
